// File: rtl/stf_sync_short.sv
// L-STF detector: lag-16 delayed autocorrelation over a 16-sample window, normalised
// against windowed power, with a plateau FSM that pulses on detection and latches the sums.
module stf_sync_short #(
    parameter int MIN_PLATEAU = 100,
    parameter int EXIT_RUN    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] sample_in,
    input  logic        sample_in_strobe,
    input  logic [3:0]  threshold,
    input  logic [35:0] min_power,
    output logic        short_preamble_detected,
    output logic [36:0] corr_re,
    output logic [36:0] corr_im,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_DETECTED = 2'd2
    } state_t;

    localparam logic [7:0] MIN_PLAT_C = 8'(MIN_PLATEAU);
    localparam logic [7:0] EXIT_RUN_C = 8'(EXIT_RUN);
    localparam logic [5:0] WARM_FULL  = 6'd32;

    // ---------------- S1: delay line and per-sample products ----------------
    logic [31:0]        delay_q [16];
    logic [5:0]         warm_cnt_q;
    logic [5:0]         warm_cnt_d;
    logic               s1_warm_d;
    logic               s1_valid_q;
    logic               s1_warm_q;
    logic signed [32:0] s1_prod_re_q;
    logic signed [32:0] s1_prod_im_q;
    logic [31:0]        s1_pwr_q;

    logic signed [31:0] in_i_x;
    logic signed [31:0] in_q_x;
    logic signed [31:0] dl_i_x;
    logic signed [31:0] dl_q_x;
    logic signed [31:0] p_id_s;
    logic signed [31:0] p_qd_s;
    logic signed [31:0] p_qi_s;
    logic signed [31:0] p_iq_s;
    logic signed [31:0] p_ii_s;
    logic signed [31:0] p_qq_s;
    logic signed [32:0] prod_re_d;
    logic signed [32:0] prod_im_d;
    logic [31:0]        pwr_d;

    // Complex product of the new sample with the conjugate of the sample 16 strobes back
    always_comb begin
        in_i_x    = {{16{sample_in[31]}}, sample_in[31:16]};
        in_q_x    = {{16{sample_in[15]}}, sample_in[15:0]};
        dl_i_x    = {{16{delay_q[15][31]}}, delay_q[15][31:16]};
        dl_q_x    = {{16{delay_q[15][15]}}, delay_q[15][15:0]};
        p_id_s    = in_i_x * dl_i_x;
        p_qd_s    = in_q_x * dl_q_x;
        p_qi_s    = in_q_x * dl_i_x;
        p_iq_s    = in_i_x * dl_q_x;
        p_ii_s    = in_i_x * in_i_x;
        p_qq_s    = in_q_x * in_q_x;
        prod_re_d = {p_id_s[31], p_id_s} + {p_qd_s[31], p_qd_s};
        prod_im_d = {p_qi_s[31], p_qi_s} - {p_iq_s[31], p_iq_s};
        pwr_d     = p_ii_s + p_qq_s;
        // This sample is the 32nd accepted one once 31 have gone before it
        s1_warm_d = (warm_cnt_q >= 6'd31);
        if (warm_cnt_q == WARM_FULL) begin
            warm_cnt_d = WARM_FULL;
        end else begin
            warm_cnt_d = warm_cnt_q + 6'd1;
        end
    end

    // S1 registers, delay line shift and warm-up counting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) delay_q[k] <= 32'd0;
            warm_cnt_q   <= 6'd0;
            s1_valid_q   <= 1'b0;
            s1_warm_q    <= 1'b0;
            s1_prod_re_q <= 33'sd0;
            s1_prod_im_q <= 33'sd0;
            s1_pwr_q     <= 32'd0;
        end else if (!enable) begin
            for (int k = 0; k < 16; k++) delay_q[k] <= 32'd0;
            warm_cnt_q   <= 6'd0;
            s1_valid_q   <= 1'b0;
            s1_warm_q    <= 1'b0;
            s1_prod_re_q <= 33'sd0;
            s1_prod_im_q <= 33'sd0;
            s1_pwr_q     <= 32'd0;
        end else begin
            s1_valid_q <= sample_in_strobe;
            if (sample_in_strobe) begin
                delay_q[0] <= sample_in;
                for (int k = 1; k < 16; k++) delay_q[k] <= delay_q[k-1];
                warm_cnt_q   <= warm_cnt_d;
                s1_warm_q    <= s1_warm_d;
                s1_prod_re_q <= prod_re_d;
                s1_prod_im_q <= prod_im_d;
                s1_pwr_q     <= pwr_d;
            end
        end
    end

    // ---------------- S2: 16-entry running window sums ----------------
    logic signed [32:0] win_re_q  [16];
    logic signed [32:0] win_im_q  [16];
    logic [31:0]        win_pwr_q [16];
    logic               s2_valid_q;
    logic               s2_warm_q;
    logic signed [36:0] sum_re_q;
    logic signed [36:0] sum_im_q;
    logic [35:0]        sum_pwr_q;
    logic signed [36:0] sum_re_d;
    logic signed [36:0] sum_im_d;
    logic [35:0]        sum_pwr_d;

    // Add the newest product, drop the one leaving the window
    always_comb begin
        sum_re_d  = sum_re_q + {{4{s1_prod_re_q[32]}}, s1_prod_re_q}
                             - {{4{win_re_q[15][32]}}, win_re_q[15]};
        sum_im_d  = sum_im_q + {{4{s1_prod_im_q[32]}}, s1_prod_im_q}
                             - {{4{win_im_q[15][32]}}, win_im_q[15]};
        sum_pwr_d = sum_pwr_q + {4'd0, s1_pwr_q} - {4'd0, win_pwr_q[15]};
    end

    // S2 window FIFOs and sums
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++) begin
                win_re_q[k]  <= 33'sd0;
                win_im_q[k]  <= 33'sd0;
                win_pwr_q[k] <= 32'd0;
            end
            s2_valid_q <= 1'b0;
            s2_warm_q  <= 1'b0;
            sum_re_q   <= 37'sd0;
            sum_im_q   <= 37'sd0;
            sum_pwr_q  <= 36'd0;
        end else if (!enable) begin
            for (int k = 0; k < 16; k++) begin
                win_re_q[k]  <= 33'sd0;
                win_im_q[k]  <= 33'sd0;
                win_pwr_q[k] <= 32'd0;
            end
            s2_valid_q <= 1'b0;
            s2_warm_q  <= 1'b0;
            sum_re_q   <= 37'sd0;
            sum_im_q   <= 37'sd0;
            sum_pwr_q  <= 36'd0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                win_re_q[0]  <= s1_prod_re_q;
                win_im_q[0]  <= s1_prod_im_q;
                win_pwr_q[0] <= s1_pwr_q;
                for (int k = 1; k < 16; k++) begin
                    win_re_q[k]  <= win_re_q[k-1];
                    win_im_q[k]  <= win_im_q[k-1];
                    win_pwr_q[k] <= win_pwr_q[k-1];
                end
                s2_warm_q <= s1_warm_q;
                sum_re_q  <= sum_re_d;
                sum_im_q  <= sum_im_d;
                sum_pwr_q <= sum_pwr_d;
            end
        end
    end

    // ---------------- S3: magnitude approximation and qualify ----------------
    logic [36:0]        abs_re_s;
    logic [36:0]        abs_im_s;
    logic [36:0]        mag_s;
    logic [40:0]        mag16_s;
    logic [40:0]        pwr_thr_s;
    logic               qual_d;
    logic               s3_valid_q;
    logic               s3_qual_q;
    logic signed [36:0] s3_re_q;
    logic signed [36:0] s3_im_q;

    // max + min/4 magnitude, compared to the threshold ratio at 41 bits
    always_comb begin
        if (sum_re_q[36]) begin
            abs_re_s = 37'd0 - sum_re_q;
        end else begin
            abs_re_s = sum_re_q;
        end
        if (sum_im_q[36]) begin
            abs_im_s = 37'd0 - sum_im_q;
        end else begin
            abs_im_s = sum_im_q;
        end
        if (abs_re_s >= abs_im_s) begin
            mag_s = abs_re_s + {2'd0, abs_im_s[36:2]};
        end else begin
            mag_s = abs_im_s + {2'd0, abs_re_s[36:2]};
        end
        mag16_s   = {mag_s, 4'd0};
        pwr_thr_s = {5'd0, sum_pwr_q} * {37'd0, threshold};
        qual_d    = s2_warm_q && (mag16_s >= pwr_thr_s) && (sum_pwr_q >= min_power);
    end

    // S3 registers: qualify flag plus the sums that produced it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_valid_q <= 1'b0;
            s3_qual_q  <= 1'b0;
            s3_re_q    <= 37'sd0;
            s3_im_q    <= 37'sd0;
        end else if (!enable) begin
            s3_valid_q <= 1'b0;
            s3_qual_q  <= 1'b0;
            s3_re_q    <= 37'sd0;
            s3_im_q    <= 37'sd0;
        end else begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_qual_q <= qual_d;
                s3_re_q   <= sum_re_q;
                s3_im_q   <= sum_im_q;
            end
        end
    end

    // ---------------- Plateau FSM ----------------
    state_t             state_q;
    logic [7:0]         plat_q;
    logic [7:0]         run_q;
    logic [7:0]         plat_inc_s;
    logic [7:0]         run_inc_s;
    logic               pulse_q;
    logic signed [36:0] lat_re_q;
    logic signed [36:0] lat_im_q;

    // Counter increments shared by the FSM branches
    always_comb begin
        plat_inc_s = plat_q + 8'd1;
        run_inc_s  = run_q + 8'd1;
    end

    // Detection FSM; the plateau count is 0 in IDLE, so IDLE and COUNT share one branch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            plat_q   <= 8'd0;
            run_q    <= 8'd0;
            pulse_q  <= 1'b0;
            lat_re_q <= 37'sd0;
            lat_im_q <= 37'sd0;
        end else if (!enable) begin
            state_q  <= ST_IDLE;
            plat_q   <= 8'd0;
            run_q    <= 8'd0;
            pulse_q  <= 1'b0;
            lat_re_q <= 37'sd0;
            lat_im_q <= 37'sd0;
        end else begin
            pulse_q <= 1'b0;
            if (s3_valid_q) begin
                case (state_q)
                    ST_IDLE, ST_COUNT: begin
                        if (s3_qual_q) begin
                            if (plat_inc_s == MIN_PLAT_C) begin
                                state_q  <= ST_DETECTED;
                                plat_q   <= 8'd0;
                                run_q    <= 8'd0;
                                pulse_q  <= 1'b1;
                                lat_re_q <= s3_re_q;
                                lat_im_q <= s3_im_q;
                            end else begin
                                state_q <= ST_COUNT;
                                plat_q  <= plat_inc_s;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            plat_q  <= 8'd0;
                        end
                    end
                    ST_DETECTED: begin
                        if (s3_qual_q) begin
                            run_q <= 8'd0;
                        end else if (run_inc_s == EXIT_RUN_C) begin
                            state_q <= ST_IDLE;
                            run_q   <= 8'd0;
                            plat_q  <= 8'd0;
                        end else begin
                            run_q <= run_inc_s;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        plat_q  <= 8'd0;
                        run_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign short_preamble_detected = pulse_q;
    assign corr_re                 = lat_re_q;
    assign corr_im                 = lat_im_q;
    assign state_out               = state_q;

endmodule

// File: tb/tb_stf_sync_short.sv
// Directed bench for stf_sync_short: zero input, periodic L-STF at two strobe rates,
// a broken plateau, enable drop mid-stream, and re-arm followed by a second detection.
module tb_stf_sync_short;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] sample_in;
    logic        sample_in_strobe;
    logic [3:0]  threshold;
    logic [35:0] min_power;
    logic        short_preamble_detected;
    logic [36:0] corr_re;
    logic [36:0] corr_im;
    logic [1:0]  state_out;

    always #5 clock = ~clock;

    stf_sync_short #(.MIN_PLATEAU(100), .EXIT_RUN(16)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .sample_in               (sample_in),
        .sample_in_strobe        (sample_in_strobe),
        .threshold               (threshold),
        .min_power               (min_power),
        .short_preamble_detected (short_preamble_detected),
        .corr_re                 (corr_re),
        .corr_im                 (corr_im),
        .state_out               (state_out)
    );

    // One period of the L-STF, scaled so that 0.046 -> 1507
    int stf_i [16] = '{1507, -4325, -426, 4686, 3015, 4686, -426, -4325,
                       1507, 66, -2589, -426, 0, -426, -2589, 66};
    int stf_q [16] = '{1507, 66, -2589, -426, 0, -426, -2589, 66,
                       1507, -4325, -426, 4686, 3015, 4686, -426, -4325};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = -1;
    int max_state = 0;
    int strobe_cyc [400];
    logic [36:0] first_re;
    logic [36:0] first_im;

    function automatic logic [31:0] stf(input int idx, input int shift);
        int a;
        int b;
        a = stf_i[idx % 16] >>> shift;
        b = stf_q[idx % 16] >>> shift;
        return {a[15:0], b[15:0]};
    endfunction

    // With a perfectly periodic window the correlation equals the period's power
    function automatic logic [36:0] period_power(input int shift);
        longint acc;
        int a;
        int b;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            a = stf_i[k] >>> shift;
            b = stf_q[k] >>> shift;
            acc += longint'(a) * a + longint'(b) * b;
        end
        return 37'(acc);
    endfunction

    task automatic tick(input logic stb, input logic [31:0] smp, input logic en);
        @(posedge clock);
        #1;
        cyc++;
        sample_in        = smp;
        sample_in_strobe = stb;
        enable           = en;
        @(negedge clock);
        if (short_preamble_detected) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        if (int'(state_out) > max_state) max_state = int'(state_out);
    endtask

    task automatic send(input int idx, input logic [31:0] smp, input int spacing);
        tick(1'b1, smp, 1'b1);
        strobe_cyc[idx] = cyc;
        for (int k = 1; k < spacing; k++) tick(1'b0, 32'd0, 1'b1);
    endtask

    task automatic clear_all();
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b0, 32'd0, 1'b0);
        pulse_cnt = 0;
        pulse_cyc = -1;
        max_state = 0;
    endtask

    task automatic flush();
        for (int k = 0; k < 8; k++) tick(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        sample_in = 32'd0;
        sample_in_strobe = 1'b0;
        threshold = 4'd12;
        min_power = 36'h100;
        repeat (3) @(negedge clock);
        n_cmp++; if (short_preamble_detected !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", short_preamble_detected); end
        n_cmp++; if (corr_re !== 37'd0) begin n_bad++; $display("FAIL reset_corr_re got %0d want 0", corr_re); end
        n_cmp++; if (corr_im !== 37'd0) begin n_bad++; $display("FAIL reset_corr_im got %0d want 0", corr_im); end
        n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state_out); end
        reset = 1'b0;
    endtask

    task automatic test_zeros();
        clear_all();
        for (int k = 0; k < 500; k++) send(0, 32'd0, 1);
        flush();
        n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL zeros_pulses got %0d want 0", pulse_cnt); end
        n_cmp++; if (max_state !== 0) begin n_bad++; $display("FAIL zeros_state got %0d want 0", max_state); end
    endtask

    task automatic test_stf_continuous();
        clear_all();
        for (int k = 0; k < 160; k++) send(k, stf(k, 0), 1);
        flush();
        first_re = corr_re;
        first_im = corr_im;
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL cont_pulses got %0d want 1", pulse_cnt); end
        n_cmp++; if (pulse_cyc !== strobe_cyc[130] + 4) begin n_bad++; $display("FAIL cont_timing got %0d want %0d", pulse_cyc, strobe_cyc[130] + 4); end
        n_cmp++; if (corr_re !== period_power(0)) begin n_bad++; $display("FAIL cont_corr_re got %0d want %0d", corr_re, period_power(0)); end
        n_cmp++; if (corr_im !== 37'd0) begin n_bad++; $display("FAIL cont_corr_im got %0d want 0", corr_im); end
        n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL cont_state got %0d want 2", state_out); end
    endtask

    task automatic test_stf_strided();
        clear_all();
        n_cmp++; if (corr_re !== 37'd0) begin n_bad++; $display("FAIL enable_clear_corr got %0d want 0", corr_re); end
        for (int k = 0; k < 160; k++) send(k, stf(k, 0), 3);
        flush();
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL stride_pulses got %0d want 1", pulse_cnt); end
        n_cmp++; if (pulse_cyc !== strobe_cyc[130] + 4) begin n_bad++; $display("FAIL stride_timing got %0d want %0d", pulse_cyc, strobe_cyc[130] + 4); end
        n_cmp++; if (corr_re !== first_re) begin n_bad++; $display("FAIL stride_corr_re got %0d want %0d", corr_re, first_re); end
        n_cmp++; if (corr_im !== first_im) begin n_bad++; $display("FAIL stride_corr_im got %0d want %0d", corr_im, first_im); end
    endtask

    task automatic test_gap();
        clear_all();
        for (int k = 0; k < 60; k++) send(k, stf(k, 0), 1);
        send(60, 32'd0, 1);
        for (int k = 0; k < 60; k++) send(61 + k, stf(k, 0), 1);
        flush();
        n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL gap_pulses got %0d want 0", pulse_cnt); end
        n_cmp++; if (max_state == 2) begin n_bad++; $display("FAIL gap_state got %0d want below 2", max_state); end
    endtask

    task automatic test_enable_drop();
        clear_all();
        for (int k = 0; k < 300; k++) begin
            if (k == 90) begin
                tick(1'b1, stf(k, 0), 1'b0);
                strobe_cyc[k] = cyc;
            end else begin
                send(k, stf(k, 0), 1);
            end
        end
        flush();
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL endrop_pulses got %0d want 1", pulse_cnt); end
        n_cmp++; if (pulse_cyc !== strobe_cyc[221] + 4) begin n_bad++; $display("FAIL endrop_timing got %0d want %0d", pulse_cyc, strobe_cyc[221] + 4); end
        n_cmp++; if (corr_re !== period_power(0)) begin n_bad++; $display("FAIL endrop_corr_re got %0d want %0d", corr_re, period_power(0)); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int k = 0; k < 160; k++) send(k, stf(k, 0), 1);
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL b2b_first_pulses got %0d want 1", pulse_cnt); end
        for (int k = 0; k < 40; k++) send(0, 32'd0, 1);
        flush();
        n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL b2b_rearm_state got %0d want 0", state_out); end
        n_cmp++; if (corr_re !== period_power(0)) begin n_bad++; $display("FAIL b2b_hold_corr_re got %0d want %0d", corr_re, period_power(0)); end
        for (int k = 0; k < 160; k++) send(k, stf(k, 1), 1);
        flush();
        n_cmp++; if (pulse_cnt !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulse_cnt); end
        n_cmp++; if (pulse_cyc < strobe_cyc[126] + 4 || pulse_cyc > strobe_cyc[130] + 4) begin
            n_bad++; $display("FAIL b2b_timing got %0d want %0d..%0d", pulse_cyc, strobe_cyc[126] + 4, strobe_cyc[130] + 4);
        end
        n_cmp++; if (corr_re !== period_power(1)) begin n_bad++; $display("FAIL b2b_corr_re got %0d want %0d", corr_re, period_power(1)); end
        n_cmp++; if (corr_im !== 37'd0) begin n_bad++; $display("FAIL b2b_corr_im got %0d want 0", corr_im); end
        n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL b2b_state got %0d want 2", state_out); end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_stf_continuous();
        test_stf_strided();
        test_gap();
        test_enable_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
